// File: rtl/residue_pkg.sv
// Shared definitions for the modulo-(2^N-1)/(2^N+1) residue datapath.
// Helper functions work on MAX_N-bit values and take the live width as an argument.
package residue_pkg;

    localparam int MAX_N     = 32;
    localparam int DEFAULT_N = 8;

    function automatic longint m1_of(input int n);
        return (longint'(1) << n) - longint'(1);
    endfunction

    function automatic longint m2_of(input int n);
        return (longint'(1) << n) + longint'(1);
    endfunction

    localparam longint M1 = m1_of(DEFAULT_N);
    localparam longint M2 = m2_of(DEFAULT_N);

    // Per-stage status shared with the forward reduction logic.
    typedef struct packed {
        logic err;
        logic valid;
    } res_status_t;

    function automatic logic [MAX_N-1:0] width_mask(input int n);
        logic [MAX_N:0] full;
        full = (MAX_N+1)'(1) << n;
        return MAX_N'(full - (MAX_N+1)'(1));
    endfunction

    // The all-ones pattern is the redundant encoding of zero mod 2^n-1.
    function automatic logic [MAX_N-1:0] mod_m1_norm(input logic [MAX_N-1:0] v, input int n);
        logic [MAX_N-1:0] mask;
        logic [MAX_N-1:0] vm;
        mask = width_mask(n);
        vm   = v & mask;
        return (vm == mask) ? '0 : vm;
    endfunction

    // Rotate right by one within n bits, i.e. multiply by 2^(n-1) mod 2^n-1.
    function automatic logic [MAX_N-1:0] rotr1(input logic [MAX_N-1:0] v, input int n);
        logic [MAX_N-1:0] mask;
        logic [MAX_N-1:0] vm;
        mask = width_mask(n);
        vm   = v & mask;
        return ((vm >> 1) | (MAX_N'(vm[0]) << (n - 1))) & mask;
    endfunction

endpackage

// File: rtl/mod_m1_sub.sv
// N-bit subtractor modulo 2^N-1: end-around carry on a + ~b, result normalized
// so that zero is always encoded as 0.
module mod_m1_sub
    import residue_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff
);

    logic [N:0]   raw;
    logic [N-1:0] eac;

    assign raw  = {1'b0, a} + {1'b0, ~b};
    assign eac  = raw[N-1:0] + {{(N-1){1'b0}}, raw[N]};
    assign diff = N'(mod_m1_norm(MAX_N'(eac), N));

endmodule

// File: rtl/residue_to_binary.sv
// Three-stage mixed-radix CRT reverse converter: (X mod 2^N-1, X mod 2^N+1) -> X.
// A single global advance signal stalls every stage together, bubbles included.
module residue_to_binary
    import residue_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_r1,
    input  logic [N:0]     in_r2,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] out_x,
    output logic           out_err
);

    localparam logic [N:0] R2_TOP = (N+1)'(1) << N;

    logic           advance;
    logic [N-1:0]   r1n_next;
    logic [N-1:0]   r2m_next;
    logic           err_next;
    logic [N-1:0]   diff;
    logic [N-1:0]   k_next;
    logic [2*N-1:0] x_next;

    res_status_t    s1_stat;
    logic [N-1:0]   s1_r1n;
    logic [N-1:0]   s1_r2m;
    logic [N:0]     s1_r2;
    res_status_t    s2_stat;
    logic [N-1:0]   s2_k;
    logic [N:0]     s2_r2;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // r2 mod 2^N-1: 2^N folds to 1, 2^N-1 folds to 0.
    always_comb begin
        r1n_next = N'(mod_m1_norm(MAX_N'(in_r1), N));
        r2m_next = N'(mod_m1_norm(MAX_N'(in_r2[N-1:0]), N));
        if (in_r2 == R2_TOP) begin
            r2m_next = N'(1);
        end
        err_next = in_valid && (in_r2 > R2_TOP);
    end

    mod_m1_sub #(.N(N)) u_sub (
        .a    (s1_r1n),
        .b    (s1_r2m),
        .diff (diff)
    );

    assign k_next = N'(rotr1(MAX_N'(diff), N));
    assign x_next = (2*N)'(s2_r2) + {s2_k, {N{1'b0}}} + (2*N)'(s2_k);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_stat   <= '0;
            s1_r1n    <= '0;
            s1_r2m    <= '0;
            s1_r2     <= '0;
            s2_stat   <= '0;
            s2_k      <= '0;
            s2_r2     <= '0;
            out_valid <= 1'b0;
            out_x     <= '0;
            out_err   <= 1'b0;
        end else if (advance) begin
            s1_stat   <= '{err: err_next, valid: in_valid};
            s1_r1n    <= r1n_next;
            s1_r2m    <= r2m_next;
            s1_r2     <= in_r2;
            s2_stat   <= s1_stat;
            s2_k      <= k_next;
            s2_r2     <= s1_r2;
            out_valid <= s2_stat.valid;
            out_err   <= s2_stat.err;
            out_x     <= s2_stat.err ? '0 : x_next;
        end
    end

endmodule

// File: tb/tb_residue_to_binary.sv
// Scoreboard bench for residue_to_binary (N=8): directed residue pairs with
// hand-computed results, a stall/backpressure stream and a mid-flight reset.
module tb_residue_to_binary;

    localparam int N = 8;

    typedef struct {
        longint x;
        bit     err;
    } exp_t;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   in_r1;
    logic [N:0]     in_r2;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] out_x;
    logic           out_err;

    exp_t           expected[$];
    int             tests_run    = 0;
    int             tests_failed = 0;
    int             accept_count = 0;
    int             pop_count    = 0;
    bit             stall_seen   = 0;
    logic [2*N-1:0] held_x;
    logic           held_err;

    residue_to_binary #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_r1     (in_r1),
        .in_r2     (in_r2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint actual, input longint required);
        tests_run++;
        if (actual != required) begin
            tests_failed++;
            $display("[TB] FAIL %s: actual %0d, required %0d", name, actual, required);
        end
    endtask

    // Holds the pair until the DUT takes it; the expected result is queued on acceptance.
    task automatic applyStimulus(input logic [N-1:0] r1, input logic [N:0] r2,
                                 input longint x, input bit err);
        int  waited = 0;
        bit  done   = 0;
        in_valid = 1'b1;
        in_r1    = r1;
        in_r2    = r2;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                expected.push_back('{x: x, err: err});
                accept_count++;
                done = 1;
            end else if (++waited > 50) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL accept_timeout: r1=%0d r2=%0d not accepted in 50 cycles", r1, r2);
                done = 1;
            end
            @(posedge clk);
            #2;
        end
        in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((expected.size() != 0 || out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_pending", expected.size(), 0);
        @(posedge clk);
        #2;
    endtask

    // Monitor: pops on each completed output handshake and checks hold-while-stalled.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && stall_seen) begin
            checkOutput("stall_hold_valid", out_valid, 1);
            checkOutput("stall_hold_x", out_x, held_x);
            checkOutput("stall_hold_err", out_err, held_err);
        end
        if (rst_n && out_valid && out_ready) begin
            if (expected.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_output: actual x=%0d err=%0d, required no output", out_x, out_err);
            end else begin
                e = expected.pop_front();
                checkOutput("result_x", out_x, e.x);
                checkOutput("result_err", out_err, e.err);
                pop_count++;
            end
        end
        stall_seen = rst_n && out_valid && !out_ready;
        held_x     = out_x;
        held_err   = out_err;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base_accept;
        int base_pop;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_r1     = '0;
        in_r2     = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_x", out_x, 0);
        checkOutput("reset_out_err", out_err, 0);
        rst_n = 1'b1;
        #1;
        checkOutput("reset_in_ready", in_ready, 1);
        @(posedge clk);
        #2;

        $display("[TB] single pair X=1000");
        applyStimulus(8'd235, 9'd229, 1000, 0);
        waitDrain();

        $display("[TB] max value then r2=2^N");
        applyStimulus(8'd254, 9'd256, 65534, 0);
        applyStimulus(8'd1,   9'd256, 256,   0);
        waitDrain();

        $display("[TB] both encodings of zero");
        applyStimulus(8'd255, 9'd0, 0, 0);
        waitDrain();
        applyStimulus(8'd0, 9'd0, 0, 0);
        waitDrain();

        $display("[TB] out-of-range r2 followed by legal pairs");
        applyStimulus(8'd17,  9'd300, 0,     1);
        applyStimulus(8'd105, 9'd9,   12345, 0);
        applyStimulus(8'd3,   9'd257, 0,     1);
        applyStimulus(8'd2,   9'd0,   257,   0);
        applyStimulus(8'd0,   9'd2,   65280, 0);
        applyStimulus(8'd0,   9'd255, 255,   0);
        applyStimulus(8'd255, 9'd511, 0,     1);
        waitDrain();

        $display("[TB] stalled stream of five");
        base_accept = accept_count;
        base_pop    = pop_count;
        out_ready   = 1'b0;
        fork
            begin
                applyStimulus(8'd235, 9'd229, 1000,  0);
                applyStimulus(8'd105, 9'd9,   12345, 0);
                applyStimulus(8'd2,   9'd0,   257,   0);
                applyStimulus(8'd0,   9'd2,   65280, 0);
                applyStimulus(8'd254, 9'd256, 65534, 0);
            end
            begin
                repeat (8) @(negedge clk);
                checkOutput("stall_accepted", accept_count - base_accept, 3);
                checkOutput("stall_in_ready", in_ready, 0);
                @(posedge clk);
                #2;
                out_ready = 1'b1;
            end
        join
        waitDrain();
        checkOutput("stall_results_out", pop_count - base_pop, 5);

        $display("[TB] reset with two pairs in flight");
        out_ready = 1'b0;
        applyStimulus(8'd235, 9'd229, 1000, 0);
        applyStimulus(8'd1,   9'd256, 256,  0);
        @(posedge clk);
        #2;
        checkOutput("pre_reset_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_async_valid", out_valid, 0);
        checkOutput("reset_async_x", out_x, 0);
        expected.delete();
        @(posedge clk);
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        checkOutput("post_reset_in_ready", in_ready, 1);
        repeat (6) begin
            @(negedge clk);
            checkOutput("post_reset_no_output", out_valid, 0);
        end
        @(posedge clk);
        #2;
        applyStimulus(8'd105, 9'd9, 12345, 0);
        waitDrain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
